mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_timeout_counter.sv | 40 ++++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
// Shared definitions for the two-requester memory bus arbiter:
//   - arb_state_t       : transfer FSM encoding (IDLE, ISSUE, BUSY, DONE)
//   - RW_* / WB_*       : polarity of the READ_WRITE and WORD_BYTE signals
//   - DEFAULT_TIMEOUT   : BUSY cycles allowed without MEM_MFC before abort
//   - cnt_width()       : bits needed to hold a count of 0..limit
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic WB_WORD  = 1'b1;
    localparam logic WB_BYTE  = 1'b0;

    localparam int DEFAULT_TIMEOUT = 15;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter
// Counts BUSY cycles of the current transfer and flags when the limit is hit.
// The count saturates at TIMEOUT and never wraps, so expired stays high
// until the next clear.
// Ports:
//   clk      in   clock, rising edge
//   reset_n  in   synchronous active-low reset
//   clear    in   restart the count at zero
//   enable   in   advance the count by one (ignored once saturated)
//   expired  out  count has reached TIMEOUT
module mem_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Round-robin arbiter that shares one memory port between requester 0
// (CPU core) and requester 1 (program loader). One transfer is in flight at
// a time; a transfer that sees no MEM_MFC within TIMEOUT+1 BUSY cycles is
// completed with ERR set.
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   req0/rw0/wb0/add0/wdat0          requester 0 request, direction, size,
//                                    address, write data
//   req1/rw1/wb1/add1/wdat1          requester 1, same meanings
//   gnt0, gnt1                       one-hot grant, ISSUE through DONE
//   mfc0, mfc1                       one-cycle completion pulse to the owner
//   rdat                             read data, valid with mfc0/mfc1
//   err                              abort pulse, coincident with mfc0/mfc1
//   mem_mfa/mem_rw/mem_wb            memory-side request, direction, size
//   mem_add, mem_wdat                registered address and write data
//   mem_rdat, mem_mfc                memory read data and completion
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              rw0,
    input  logic              wb0,
    input  logic [ADDR_W-1:0] add0,
    input  logic [31:0]       wdat0,
    input  logic              req1,
    input  logic              rw1,
    input  logic              wb1,
    input  logic [ADDR_W-1:0] add1,
    input  logic [31:0]       wdat1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              mfc0,
    output logic              mfc1,
    output logic [31:0]       rdat,
    output logic              err,
    output logic              mem_mfa,
    output logic              mem_rw,
    output logic              mem_wb,
    output logic [ADDR_W-1:0] mem_add,
    output logic [31:0]       mem_wdat,
    input  logic [31:0]       mem_rdat,
    input  logic              mem_mfc
);

    arb_state_t  state;
    arb_state_t  next_state;
    logic        owner;
    logic        last;
    logic        winner;
    logic        any_req;
    logic        abort;
    logic [31:0] rdat_q;
    logic        expired;
    logic        cnt_clear;
    logic        cnt_enable;

    // On a tie the requester that was not served last wins; otherwise
    // whichever one is asking.
    always_comb begin
        any_req = req0 | req1;
        winner  = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completion in the last allowed BUSY cycle still counts as success;
    // only a missing MEM_MFC with the counter expired aborts.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (any_req) next_state = ST_ISSUE;
            ST_ISSUE: next_state = ST_BUSY;
            ST_BUSY:  if (mem_mfc || expired) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Memory-side registers only load in IDLE, so they hold steady for the
    // whole transfer and no request input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last     <= 1'b1;
            owner    <= 1'b0;
            abort    <= 1'b0;
            rdat_q   <= '0;
            mem_rw   <= RW_READ;
            mem_wb   <= WB_WORD;
            mem_add  <= '0;
            mem_wdat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        last     <= winner;
                        abort    <= 1'b0;
                        rdat_q   <= '0;
                        mem_rw   <= winner ? rw1   : rw0;
                        mem_wb   <= winner ? wb1   : wb0;
                        mem_add  <= winner ? add1  : add0;
                        mem_wdat <= winner ? wdat1 : wdat0;
                    end
                end
                ST_BUSY: begin
                    if (mem_mfc) begin
                        if (mem_rw == RW_READ) begin
                            rdat_q <= mem_rdat;
                        end
                    end else if (expired) begin
                        abort <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cnt_clear  = (state == ST_ISSUE);
    assign cnt_enable = (state == ST_BUSY) && !mem_mfc;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    assign gnt0    = (state != ST_IDLE) && !owner;
    assign gnt1    = (state != ST_IDLE) &&  owner;
    assign mfc0    = (state == ST_DONE) && !owner;
    assign mfc1    = (state == ST_DONE) &&  owner;
    assign err     = (state == ST_DONE) && abort;
    assign rdat    = (state == ST_DONE) ? rdat_q : 32'd0;
    assign mem_mfa = (state == ST_ISSUE) || (state == ST_BUSY);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed scenarios (single read, contention, timeout, reset mid-transfer,
// spurious completion) followed by a randomized run checked against a
// transaction-level timing model of the arbiter.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TIMEOUT = DEFAULT_TIMEOUT;

    logic        clk;
    logic        reset_n;
    logic        req0, rw0, wb0, req1, rw1, wb1;
    logic [7:0]  add0, add1;
    logic [31:0] wdat0, wdat1;
    logic        gnt0, gnt1, mfc0, mfc1, err;
    logic [31:0] rdat;
    logic        mem_mfa, mem_rw, mem_wb;
    logic [7:0]  mem_add;
    logic [31:0] mem_wdat;
    logic [31:0] mem_rdat;
    logic        mem_mfc;

    int compared   = 0;
    int mismatched = 0;

    mem_bus_arbiter #(
        .ADDR_W  (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .rw0      (rw0),
        .wb0      (wb0),
        .add0     (add0),
        .wdat0    (wdat0),
        .req1     (req1),
        .rw1      (rw1),
        .wb1      (wb1),
        .add1     (add1),
        .wdat1    (wdat1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .mfc0     (mfc0),
        .mfc1     (mfc1),
        .rdat     (rdat),
        .err      (err),
        .mem_mfa  (mem_mfa),
        .mem_rw   (mem_rw),
        .mem_wb   (mem_wb),
        .mem_add  (mem_add),
        .mem_wdat (mem_wdat),
        .mem_rdat (mem_rdat),
        .mem_mfc  (mem_mfc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic mfc);
        req0    = r0;
        req1    = r1;
        mem_mfc = mfc;
    endtask

    task automatic doReset();
        reset_n  = 1'b0;
        mem_rdat = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gnt0"},     64'(gnt0),     64'd0);
        checkOutput({tag, "_gnt1"},     64'(gnt1),     64'd0);
        checkOutput({tag, "_mfc0"},     64'(mfc0),     64'd0);
        checkOutput({tag, "_mfc1"},     64'(mfc1),     64'd0);
        checkOutput({tag, "_err"},      64'(err),      64'd0);
        checkOutput({tag, "_rdat"},     64'(rdat),     64'd0);
        checkOutput({tag, "_mem_mfa"},  64'(mem_mfa),  64'd0);
        checkOutput({tag, "_mem_rw"},   64'(mem_rw),   64'd1);
        checkOutput({tag, "_mem_wb"},   64'(mem_wb),   64'd1);
        checkOutput({tag, "_mem_add"},  64'(mem_add),  64'd0);
        checkOutput({tag, "_mem_wdat"}, 64'(mem_wdat), 64'd0);
    endtask

    // Requester-side stimulus state for the randomized run
    logic        rq   [2];
    logic        rw_a [2];
    logic        wb_a [2];
    logic [7:0]  ad_a [2];
    logic [31:0] wd_a [2];

    // Transaction-level model: one record for the transfer most recently
    // granted, plus the cycle from which the arbiter can accept another.
    int          free_at;
    int          last_m;
    bit          cur_valid;
    int          cur_owner, cur_n, cur_done, cur_mfc_at;
    bit          cur_abort;
    logic        cur_rw, cur_wb;
    logic [7:0]  cur_add;
    logic [31:0] cur_wdat, cur_rdata;
    logic [41:0] exp_mem;
    logic [5:0]  exp_ctl;
    bit          do_reset, in_busy, in_win, at_done;
    int          w, d;

    // Directed-scenario bookkeeping
    int          first_k, pulses, both_gnt, mfa_cycles;
    logic [31:0] seen_rdat;
    logic        seen_err, seen_rw;
    logic [7:0]  seen_add;
    logic [31:0] seen_wdat;
    int          ids [$];

    task automatic newAttrs(input int i);
        rw_a[i] = 1'($urandom_range(0, 1));
        wb_a[i] = 1'($urandom_range(0, 1));
        ad_a[i] = 8'($urandom);
        wd_a[i] = $urandom;
    endtask

    initial begin
        reset_n = 1'b0;
        rw0 = 1'b1; wb0 = 1'b1; add0 = 8'd0; wdat0 = 32'd0;
        rw1 = 1'b1; wb1 = 1'b1; add1 = 8'd0; wdat1 = 32'd0;
        mem_rdat = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Reset values
        doReset();
        @(negedge clk);
        checkResetValues("reset");

        // Single read, memory completes on the 2nd BUSY cycle
        doReset();
        rw0 = RW_READ; wb0 = WB_WORD; add0 = 8'h10; wdat0 = 32'd0;
        mem_rdat = 32'hDEADBEEF;
        first_k = -1; pulses = 0;
        seen_rdat = '0; seen_err = 1'b1; seen_add = '0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(k < 4, 1'b0, k == 3);
            @(negedge clk);
            if (k == 1) begin
                checkOutput("read_issue_gnt0", 64'(gnt0), 64'd1);
                checkOutput("read_issue_mfa", 64'(mem_mfa), 64'd1);
            end
            if (mfc0) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k; seen_rdat = rdat; seen_err = err; seen_add = mem_add;
                end
            end
            nextCycle();
        end
        checkOutput("read_latency", 64'(first_k), 64'd4);
        checkOutput("read_pulses", 64'(pulses), 64'd1);
        checkOutput("read_rdat", 64'(seen_rdat), 64'hDEADBEEF);
        checkOutput("read_err", 64'(seen_err), 64'd0);
        checkOutput("read_mem_add", 64'(seen_add), 64'h10);

        // Contention: both held, memory always ready
        doReset();
        rw0 = RW_READ; rw1 = RW_WRITE; add0 = 8'h01; add1 = 8'h02;
        applyStimulus(1'b1, 1'b1, 1'b1);
        ids.delete(); first_k = -1; both_gnt = 0;
        for (int k = 0; k < 40 && ids.size() < 4; k++) begin
            @(negedge clk);
            if (gnt0 && gnt1) both_gnt++;
            if (mfc0) ids.push_back(0);
            if (mfc1) ids.push_back(1);
            if ((mfc0 || mfc1) && first_k < 0) first_k = k;
            nextCycle();
        end
        checkOutput("contend_latency", 64'(first_k), 64'd3);
        checkOutput("contend_count", 64'(ids.size()), 64'd4);
        for (int j = 0; j < 4; j++) begin
            checkOutput("contend_order", 64'((j < ids.size()) ? ids[j] : 99), 64'(j % 2));
        end
        checkOutput("contend_onehot", 64'(both_gnt), 64'd0);

        // Timeout: write from requester 1, memory never answers
        doReset();
        rw1 = RW_WRITE; wb1 = WB_WORD; add1 = 8'h20; wdat1 = 32'h12345678;
        first_k = -1; mfa_cycles = 0;
        seen_rdat = 32'hFFFFFFFF; seen_err = 1'b0; seen_add = '0; seen_rw = 1'b1; seen_wdat = '0;
        for (int k = 0; k < 60 && first_k < 0; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (mem_mfa) mfa_cycles++;
            if (mfc1) begin
                first_k = k; seen_rdat = rdat; seen_err = err;
                seen_add = mem_add; seen_rw = mem_rw; seen_wdat = mem_wdat;
            end
            nextCycle();
        end
        checkOutput("timeout_done_cycle", 64'(first_k), 64'(TIMEOUT + 3));
        checkOutput("timeout_mfa_cycles", 64'(mfa_cycles), 64'(TIMEOUT + 2));
        checkOutput("timeout_err", 64'(seen_err), 64'd1);
        checkOutput("timeout_rdat", 64'(seen_rdat), 64'd0);
        checkOutput("timeout_mem_add", 64'(seen_add), 64'h20);
        checkOutput("timeout_mem_rw", 64'(seen_rw), 64'(RW_WRITE));
        checkOutput("timeout_mem_wdat", 64'(seen_wdat), 64'h12345678);

        // Reset on the 3rd BUSY cycle aborts silently
        doReset();
        rw0 = RW_READ; wb0 = WB_BYTE; add0 = 8'h55; wdat0 = 32'hA5A5A5A5;
        mem_rdat = 32'h0BADF00D;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            reset_n = (k != 4);
            applyStimulus(k < 4, 1'b0, 1'b0);
            @(negedge clk);
            if (k == 4) checkOutput("midbusy_in_busy", 64'(mem_mfa), 64'd1);
            if (k == 5) checkResetValues("midbusy");
            if (mfc0 || mfc1 || err) pulses++;
            nextCycle();
        end
        checkOutput("midbusy_pulses", 64'(pulses), 64'd0);

        // Spurious MEM_MFC in IDLE
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput("spurious_idle", 64'({gnt1, gnt0, mfc1, mfc0, err, mem_mfa}), 64'd0);
            nextCycle();
        end

        // Randomized run against the transaction model
        doReset();
        free_at = 0; last_m = 1; cur_valid = 0;
        cur_owner = 0; cur_n = 0; cur_done = 0; cur_mfc_at = -1; cur_abort = 0;
        exp_mem = {RW_READ, WB_WORD, 8'h00, 32'h0};
        for (int i = 0; i < 2; i++) begin
            rq[i] = 1'b0;
            newAttrs(i);
        end
        for (int m = 0; m < 3000; m++) begin
            do_reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (cur_valid && cur_owner == i && m > cur_n && m <= cur_done) begin
                    if (rq[i] && $urandom_range(0, 7) == 0) rq[i] = 1'b0;
                end else if (cur_valid && cur_owner == i && m == cur_done + 1) begin
                    if ($urandom_range(0, 1) == 1) begin
                        rq[i] = 1'b1;
                        newAttrs(i);
                    end else begin
                        rq[i] = 1'b0;
                    end
                end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
                    rq[i] = 1'b1;
                    newAttrs(i);
                end
            end

            if (!do_reset && m >= free_at && (rq[0] || rq[1])) begin
                w = (rq[0] && rq[1]) ? (1 - last_m) : (rq[1] ? 1 : 0);
                last_m    = w;
                cur_valid = 1;
                cur_owner = w;
                cur_n     = m;
                cur_rw    = rw_a[w];
                cur_wb    = wb_a[w];
                cur_add   = ad_a[w];
                cur_wdat  = wd_a[w];
                cur_rdata = $urandom;
                d         = $urandom_range(1, TIMEOUT + 2);
                cur_abort = (d == TIMEOUT + 2);
                cur_mfc_at = cur_abort ? -1 : m + 1 + d;
                cur_done   = m + 2 + (cur_abort ? TIMEOUT + 1 : d);
                free_at    = cur_done + 1;
            end

            in_busy = cur_valid && m >= cur_n + 2 && m < cur_done;
            if (in_busy) begin
                mem_mfc  = (m == cur_mfc_at);
                mem_rdat = (m == cur_mfc_at) ? cur_rdata : $urandom;
            end else begin
                mem_mfc  = ($urandom_range(0, 3) == 0);
                mem_rdat = $urandom;
            end
            reset_n = !do_reset;
            req0 = rq[0]; rw0 = rw_a[0]; wb0 = wb_a[0]; add0 = ad_a[0]; wdat0 = wd_a[0];
            req1 = rq[1]; rw1 = rw_a[1]; wb1 = wb_a[1]; add1 = ad_a[1]; wdat1 = wd_a[1];

            @(negedge clk);
            if (cur_valid && m == cur_n + 1) exp_mem = {cur_rw, cur_wb, cur_add, cur_wdat};
            in_win  = cur_valid && m > cur_n && m <= cur_done;
            at_done = cur_valid && m == cur_done;
            exp_ctl = {in_win && cur_owner == 1, in_win && cur_owner == 0,
                       at_done && cur_owner == 1, at_done && cur_owner == 0,
                       at_done && cur_abort, cur_valid && m > cur_n && m < cur_done};
            checkOutput("rnd_ctl", 64'({gnt1, gnt0, mfc1, mfc0, err, mem_mfa}), 64'(exp_ctl));
            checkOutput("rnd_rdat", 64'(rdat),
                        (at_done && cur_rw == RW_READ && !cur_abort) ? 64'(cur_rdata) : 64'd0);
            checkOutput("rnd_mem", 64'({mem_rw, mem_wb, mem_add, mem_wdat}), 64'(exp_mem));

            if (do_reset) begin
                cur_valid = 0;
                last_m    = 1;
                free_at   = m + 1;
                exp_mem   = {RW_READ, WB_WORD, 8'h00, 32'h0};
                rq[0]     = 1'b0;
                rq[1]     = 1'b0;
            end
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
